alu_serial_exec: RTL and testbench

Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation. Single-cycle operations take one cycle; shifts iterate one bit position per cycle unless the fast-shift option is compiled in. It sits in the execute stage between the ALU control decoder and the write-back mux, and uses a Start/Busy/Done handshake so the control FSM can stall on long shifts.

---
 rtl/alu_serial_exec.sv | 173 +++++++++++++++++
 tb/tb_alu_serial_exec.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_exec.sv
// Multi-cycle execute unit with a serial shifter and Start/Busy/Done handshake.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter by a barrel shifter.
module alu_serial_exec (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic [3:0]  ALUCtrl,
   input  logic [31:0] BusA,
   input  logic [31:0] BusB,
   input  logic [4:0]  Shamt,
   output logic [31:0] BusW,
   output logic        Zero,
   output logic        Overflow,
   output logic        IllegalOp,
   output logic        Busy,
   output logic        Done
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_ADDU = 4'b1000;
   localparam logic [3:0] OP_SUBU = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_LUI  = 4'b1110;

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic [1:0] {IDLE, EXEC} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
`endif

   state_t state, state_nx;

   logic [31:0] res, sum, dif;
   logic        ovf, ill, accept;

   assign sum    = BusA + BusB;
   assign dif    = BusA - BusB;
   assign accept = (state == IDLE) && Start;

   // Result of the captured operation when it completes in a single cycle
   always_comb begin
      res = '0;
      ovf = 1'b0;
      ill = 1'b0;
      case (ALUCtrl)
         OP_AND:  res = BusA & BusB;
         OP_OR:   res = BusA | BusB;
         OP_ADD: begin
            res = sum;
            ovf = (BusA[31] == BusB[31]) && (sum[31] != BusA[31]);
         end
         OP_SUB: begin
            res = dif;
            ovf = (BusA[31] != BusB[31]) && (dif[31] != BusA[31]);
         end
         OP_SLT:  res = {31'd0, $signed(BusA) < $signed(BusB)};
         OP_ADDU: res = sum;
         OP_SUBU: res = dif;
         OP_XOR:  res = BusA ^ BusB;
         OP_SLTU: res = {31'd0, BusA < BusB};
         OP_NOR:  res = ~(BusA | BusB);
         OP_LUI:  res = {BusB[15:0], 16'd0};
`ifdef ALU_FAST_SHIFT_EN
         OP_SLL:  res = BusB << Shamt;
         OP_SRL:  res = BusB >> Shamt;
         OP_SRA:  res = $signed(BusB) >>> Shamt;
`else
         OP_SLL,
         OP_SRL,
         OP_SRA:  res = BusB;
`endif
         default: ill = 1'b1;
      endcase
   end

`ifndef ALU_FAST_SHIFT_EN
   logic [3:0]  op;
   logic [31:0] work, sh_nx;
   logic [4:0]  cnt;
   logic        long_sh;

   assign long_sh = (ALUCtrl == OP_SLL || ALUCtrl == OP_SRL ||
                     ALUCtrl == OP_SRA) && (Shamt != 5'd0);

   always_comb begin
      sh_nx = {work[31], work[31:1]};
      if (op == OP_SLL)
         sh_nx = {work[30:0], 1'b0};
      else if (op == OP_SRL)
         sh_nx = {1'b0, work[31:1]};
   end
`endif

   always_ff @(posedge CLK) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      Busy     = (state != IDLE);
      Done     = (state == EXEC);
      case (state)
         IDLE: begin
            if (Start) begin
`ifndef ALU_FAST_SHIFT_EN
               if (long_sh)
                  state_nx = SHIFT;
               else
`endif
                  state_nx = EXEC;
            end
         end
         EXEC: state_nx = IDLE;
`ifndef ALU_FAST_SHIFT_EN
         SHIFT: if (cnt == 5'd1) state_nx = EXEC;
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         BusW      <= '0;
         Zero      <= 1'b1;
         Overflow  <= 1'b0;
         IllegalOp <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
         op        <= '0;
         work      <= '0;
         cnt       <= '0;
`endif
      end else begin
`ifndef ALU_FAST_SHIFT_EN
         if (accept) begin
            op   <= ALUCtrl;
            work <= BusB;
            cnt  <= Shamt;
         end else if (state == SHIFT) begin
            work <= sh_nx;
            cnt  <= cnt - 5'd1;
            // Last shift step lands straight in the result register
            if (cnt == 5'd1) begin
               BusW      <= sh_nx;
               Zero      <= (sh_nx == '0);
               Overflow  <= 1'b0;
               IllegalOp <= 1'b0;
            end
         end
         if (accept && !long_sh) begin
`else
         if (accept) begin
`endif
            BusW      <= res;
            Zero      <= (res == '0);
            Overflow  <= ovf;
            IllegalOp <= ill;
         end
      end
   end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed-vector bench for alu_serial_exec.
// Latency expectations follow ALU_FAST_SHIFT_EN when it is defined.
module tb_alu_serial_exec;

   logic        CLK = 1'b0;
   logic        Reset, Start;
   logic [3:0]  ALUCtrl;
   logic [31:0] BusA, BusB;
   logic [4:0]  Shamt;
   logic [31:0] BusW;
   logic        Zero, Overflow, IllegalOp, Busy, Done;

   int nchk = 0;
   int nerr = 0;

   alu_serial_exec dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
      .BusA(BusA), .BusB(BusB), .Shamt(Shamt), .BusW(BusW),
      .Zero(Zero), .Overflow(Overflow), .IllegalOp(IllegalOp),
      .Busy(Busy), .Done(Done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [3:0] c, input logic [4:0] s);
`ifdef ALU_FAST_SHIFT_EN
      return 1;
`else
      if (c == 4'b0011 || c == 4'b0100 || c == 4'b1101) return int'(s) + 1;
      return 1;
`endif
   endfunction

   // Issue one op from idle, wait for Done, check result, flags, latency
   task automatic do_op(input string tag, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] ew,
                        input logic eo, input logic ei);
      int  lat;
      bit  busy_bad;
      @(negedge CLK);
      ALUCtrl = c; BusA = a; BusB = b; Shamt = s; Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      BusA = ~a; BusB = ~b;
      lat = 1;
      busy_bad = 1'b0;
      @(negedge CLK);
      while (!Done && lat < 64) begin
         if (!Busy) busy_bad = 1'b1;
         @(negedge CLK);
         lat++;
      end
      if (!Busy) busy_bad = 1'b1;
      check({tag, ".lat"}, lat, exp_lat(c, s));
      check({tag, ".busw"}, BusW, ew);
      check({tag, ".zero"}, {31'd0, Zero}, {31'd0, ew == 32'd0});
      check({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, eo});
      check({tag, ".ill"}, {31'd0, IllegalOp}, {31'd0, ei});
      check({tag, ".busy"}, {31'd0, busy_bad}, 32'd0);
      @(negedge CLK);
      check({tag, ".idle"}, {30'd0, Busy, Done}, 32'd0);
   endtask

   initial begin
      int cyc, ndone;
      Reset = 1'b1; Start = 1'b0; ALUCtrl = '0;
      BusA = '0; BusB = '0; Shamt = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst.busw", BusW, 32'd0);
      check("rst.flags", {27'd0, Zero, Overflow, IllegalOp, Busy, Done},
            32'b10000);
      Reset = 1'b0;

      do_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1, 0);
      do_op("addu",     4'b1000, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 0, 0);
      do_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 32'd0, 0, 0);
      do_op("sub_ovf",  4'b0110, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1, 0);
      do_op("subu",     4'b1001, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 0, 0);
      do_op("slt",      4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0, 32'd1, 0, 0);
      do_op("sltu",     4'b1011, 32'hFFFFFFFF, 32'h1, 5'd0, 32'd0, 0, 0);
      do_op("and",      4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 0, 0);
      do_op("or",       4'b0001, 32'h000000F0, 32'h00000F00, 5'd0, 32'h00000FF0, 0, 0);
      do_op("xor",      4'b1010, 32'hA5A5A5A5, 32'hFFFF0000, 5'd0, 32'h5A5AA5A5, 0, 0);
      do_op("nor",      4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 0, 0);
      do_op("ill5",     4'b0101, 32'h12345678, 32'h1, 5'd0, 32'd0, 0, 1);
      do_op("illf",     4'b1111, 32'h12345678, 32'h1, 5'd0, 32'd0, 0, 1);
      do_op("lui",      4'b1110, 32'hDEADBEEF, 32'hFFFF1234, 5'd0, 32'h12340000, 0, 0);
      do_op("sra31",    4'b1101, 32'd0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 0, 0);
      do_op("srl0",     4'b0100, 32'd0, 32'h80000001, 5'd0, 32'h80000001, 0, 0);
      do_op("srl4",     4'b0100, 32'd0, 32'h80000010, 5'd4, 32'h08000001, 0, 0);
      do_op("sra4pos",  4'b1101, 32'd0, 32'h40000000, 5'd4, 32'h04000000, 0, 0);
      do_op("sll1",     4'b0011, 32'd0, 32'h80000001, 5'd1, 32'h00000002, 0, 0);

      // SLL 8 with an ignored re-pulse of Start at cycle 3
      @(negedge CLK);
      ALUCtrl = 4'b0011; BusA = '0; BusB = 32'hFF; Shamt = 5'd8; Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      cyc = 1;
      @(negedge CLK);
      while (!Done && cyc < 64) begin
         if (cyc == 3) begin
            ALUCtrl = 4'b0010; BusA = 32'd1; BusB = 32'd1; Start = 1'b1;
         end else
            Start = 1'b0;
         @(negedge CLK);
         cyc++;
      end
      Start = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
      check("repulse.cyc", cyc, 1);
`else
      check("repulse.cyc", cyc, 9);
`endif
      check("repulse.busw", BusW, 32'h0000FF00);
      @(negedge CLK);
      check("repulse.idle", {30'd0, Busy, Done}, 32'd0);

      // Reset at cycle 4 of SRL 20 aborts the shift
      ALUCtrl = 4'b0100; BusA = '0; BusB = 32'hF0000000; Shamt = 5'd20;
      Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge CLK);
         if (Done) ndone++;
      end
      @(negedge CLK);
      if (Done) ndone++;
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      if (Done) ndone++;
`ifdef ALU_FAST_SHIFT_EN
      check("abort.ndone", ndone, 1);
`else
      check("abort.ndone", ndone, 0);
`endif
      check("abort.busy", {31'd0, Busy}, 32'd0);
      check("abort.busw", BusW, 32'd0);
      check("abort.zero", {31'd0, Zero}, 32'd1);

      // Reset and Start together: Start dropped
      @(negedge CLK);
      ALUCtrl = 4'b0010; BusA = 32'd7; BusB = 32'd8; Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      Reset = 1'b0;
      check("rststart.busy", {30'd0, Busy, Done}, 32'd0);
      check("rststart.busw", BusW, 32'd0);

      do_op("and_after", 4'b0000, 32'hFFFF00FF, 32'h0F0F0F0F, 5'd0,
            32'h0F0F000F, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
